addr_decoder: RTL and testbench
===============================

Name: addr_decoder

Overview:
- Address decoder and response multiplexer between a single bus master port and NUM_SLAVES memory-mapped slaves.
- Decodes the global address into a one-hot slave select and translates it to a slave-local offset. Forwards write data and write enable, and routes the selected slave's read data and ready/err back to the master.
- Unmapped addresses get an immediate error response. A clocked watchdog terminates stalled transfers with an error, and a saturating counter records error completions.

Parameters:
- ADDR_WIDTH, 14: master/slave address width.
- DATA_WIDTH, 8: data width.
- NUM_SLAVES, 3: number of slaves.
- SLAVE0_BASE 0x0000, SLAVE0_SIZE 0x1000; SLAVE1_BASE 0x1000, SLAVE1_SIZE 0x1000; SLAVE2_BASE 0x2000, SLAVE2_SIZE 0x0800: slave windows.
- TIMEOUT_CYCLES, 16: stall cycles before the watchdog error.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- valid_i, in, 1: master request valid.
- addr_i, in, ADDR_WIDTH: global address.
- wdata_i, in, DATA_WIDTH: write data.
- we_i, in, 1: write enable.
- ready_o, out, 1: transfer complete.
- rdata_o, out, DATA_WIDTH: read data to master.
- err_o, out, 1: error response (valid only with ready_o).
- slave_sel_o, out, NUM_SLAVES: one-hot address-decode select.
- slave_valid_o, out, NUM_SLAVES: per-slave request.
- slave_addr_o, out, ADDR_WIDTH: slave-local address.
- slave_wdata_o, out, DATA_WIDTH: forwarded write data.
- slave_we_o, out, 1: forwarded write enable.
- slave_ready_i, in, NUM_SLAVES: per-slave ready.
- slave_rdata_i, in, unpacked array [NUM_SLAVES] of DATA_WIDTH: per-slave read data.
- slave_err_i, in, NUM_SLAVES: per-slave error.
- err_count_o, out, 8: saturating count of error completions.

Behaviour:
- Decode (combinational, independent of valid_i):
  - sel[i]=1 iff BASEi <= addr_i < BASEi+SIZEi.
  - At most one bit is set. decode_err = (sel == 0).
  - slave_sel_o = sel, so addr 0 with valid_i=0 gives 001.
- slave_valid_o = sel & {NUM_SLAVES{valid_i}}. This is zero when idle or when the address is unmapped.
- slave_addr_o = addr_i − BASE of the selected slave, truncated to ADDR_WIDTH. It is addr_i unchanged when decode_err.
- slave_wdata_o = wdata_i and slave_we_o = we_i, forwarded unconditionally.
- rdata_o = slave_rdata_i[selected]; it is 0 when decode_err.
- ready_o = valid_i & (decode_err | slave_ready_i[selected] | timeout).
- err_o = valid_i & (decode_err | (slave_ready_i[selected] & slave_err_i[selected]) | timeout).
- Unmapped address with valid_i=1 (e.g. 0x2800, 0x3FFF): ready_o=1 and err_o=1 in the same cycle, with zero latency.
- All paths except the watchdog and the counter are combinational, so a response is visible in the same cycle the slave drives it.
- Watchdog:
  - stall_cnt register, width clog2(TIMEOUT_CYCLES+1), reset value 0.
  - Each posedge: if valid_i & ~decode_err & ~slave_ready_i[selected] & ~timeout, increment; otherwise clear to 0.
  - timeout = (stall_cnt == TIMEOUT_CYCLES), asserted combinationally. The counter clears on the next edge.
  - A request accepted within TIMEOUT_CYCLES cycles never times out.
  - An address change mid-stall does not clear the counter.
- err_count_o:
  - Register with reset value 0.
  - Increments on each posedge where valid_i & ready_o & err_o.
  - Saturates at 0xFF.
- Reset: asynchronous on rst_ni low, clearing stall_cnt and err_count_o to 0. Combinational outputs stay live during reset; timeout is 0 while stall_cnt=0.
- No transaction state is held; the master must hold inputs stable until ready_o.

Test Plan:
- valid_i=0, addr=0 → slave_valid=000, slave_sel=001, err_count_o=0 after reset.
- Decode, valid_i=1, we_i=1, wdata 0x42:
  - 0x0000 and 0x0FFF → sel=001.
  - 0x1000 and 0x1FFF → sel=010.
  - 0x2000 and 0x27FF → sel=100.
  - slave_valid equals sel in each case; local addresses 0x000 / 0xFFF / 0x000 / 0xFFF / 0x000 / 0x7FF; slave_wdata=0x42; slave_we=1.
- Unmapped 0x2800 and 0x3FFF with valid_i=1 → sel=000, slave_valid=000, ready=1, err=1; err_count_o increments by 1 per cycle held.
- Read routing:
  - addr 0x0500 with slave0 ready, rdata 0xAB → rdata_o=0xAB, ready=1, err=0.
  - 0x1800 with slave1 returning 0xCD, and 0x2100 with slave2 returning 0xEF, give the same behaviour.
  - Translation: 0x0100, 0x1100 and 0x2100 → local 0x0100.
- Slave error: addr BASEi+0x100 with slave_ready[i]=slave_err[i]=1 → ready=1, err=1, for i = 0, 1 and 2.
- Watchdog: valid_i=1 at 0x1000 with slave_ready=0 → ready=0 for 16 cycles, ready=err=1 on the 17th, then the counter restarts. Asserting rst_ni low mid-stall clears the count immediately.

Source files
------------

// File: rtl/addr_decoder.sv
// rtl/addr_decoder.sv - one-master to NUM_SLAVES address decoder with response mux, stall watchdog and error counter
module addr_decoder #(
    parameter int          ADDR_WIDTH     = 14,
    parameter int          DATA_WIDTH     = 8,
    parameter int          NUM_SLAVES     = 3,
    parameter int unsigned SLAVE0_BASE    = 'h0000,
    parameter int unsigned SLAVE0_SIZE    = 'h1000,
    parameter int unsigned SLAVE1_BASE    = 'h1000,
    parameter int unsigned SLAVE1_SIZE    = 'h1000,
    parameter int unsigned SLAVE2_BASE    = 'h2000,
    parameter int unsigned SLAVE2_SIZE    = 'h0800,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic [NUM_SLAVES-1:0] slave_sel_o,
    output logic [NUM_SLAVES-1:0] slave_valid_o,
    output logic [ADDR_WIDTH-1:0] slave_addr_o,
    output logic [DATA_WIDTH-1:0] slave_wdata_o,
    output logic                  slave_we_o,
    input  logic [NUM_SLAVES-1:0] slave_ready_i,
    input  logic [DATA_WIDTH-1:0] slave_rdata_i [NUM_SLAVES],
    input  logic [NUM_SLAVES-1:0] slave_err_i,
    output logic [7:0]            err_count_o
);

    localparam int AW1 = ADDR_WIDTH + 1;
    localparam int SW  = $clog2(TIMEOUT_CYCLES + 1);

    // Slaves beyond the third get an empty window and never decode.
    function automatic logic [ADDR_WIDTH-1:0] win_base(input int idx);
        case (idx)
            0:       win_base = ADDR_WIDTH'(SLAVE0_BASE);
            1:       win_base = ADDR_WIDTH'(SLAVE1_BASE);
            2:       win_base = ADDR_WIDTH'(SLAVE2_BASE);
            default: win_base = '0;
        endcase
    endfunction

    function automatic logic [ADDR_WIDTH:0] win_size(input int idx);
        case (idx)
            0:       win_size = AW1'(SLAVE0_SIZE);
            1:       win_size = AW1'(SLAVE1_SIZE);
            2:       win_size = AW1'(SLAVE2_SIZE);
            default: win_size = '0;
        endcase
    endfunction

    logic [NUM_SLAVES-1:0] sel;
    logic [ADDR_WIDTH-1:0] sel_base;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  sel_ready;
    logic                  sel_err;
    logic                  decode_err;
    logic                  timeout;
    logic [SW-1:0]         stall_cnt;

    // Windows are disjoint, so at most one iteration hits and the mux is a plain OR of one.
    always_comb begin
        sel       = '0;
        sel_base  = '0;
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (({1'b0, addr_i} >= {1'b0, win_base(i)}) &&
                ({1'b0, addr_i} <  ({1'b0, win_base(i)} + win_size(i)))) begin
                sel[i]    = 1'b1;
                sel_base  = win_base(i);
                sel_rdata = slave_rdata_i[i];
                sel_ready = slave_ready_i[i];
                sel_err   = slave_err_i[i];
            end
        end
    end

    assign decode_err    = ~|sel;
    assign timeout       = (stall_cnt == SW'(TIMEOUT_CYCLES));

    assign slave_sel_o   = sel;
    assign slave_valid_o = sel & {NUM_SLAVES{valid_i}};
    assign slave_addr_o  = addr_i - sel_base;
    assign slave_wdata_o = wdata_i;
    assign slave_we_o    = we_i;

    assign rdata_o = sel_rdata;
    assign ready_o = valid_i & (decode_err | sel_ready | timeout);
    assign err_o   = valid_i & (decode_err | (sel_ready & sel_err) | timeout);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt   <= '0;
            err_count_o <= '0;
        end else begin
            if (valid_i && !decode_err && !sel_ready && !timeout)
                stall_cnt <= stall_cnt + SW'(1);
            else
                stall_cnt <= '0;
            if (valid_i && ready_o && err_o && (err_count_o != 8'hFF))
                err_count_o <= err_count_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_addr_decoder.sv
// tb/tb_addr_decoder.sv - scoreboard bench for addr_decoder with directed vectors
module tb_addr_decoder;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic [13:0] addr_i = '0;
    logic [7:0]  wdata_i = '0;
    logic        we_i = 1'b0;
    logic        ready_o;
    logic [7:0]  rdata_o;
    logic        err_o;
    logic [2:0]  slave_sel_o;
    logic [2:0]  slave_valid_o;
    logic [13:0] slave_addr_o;
    logic [7:0]  slave_wdata_o;
    logic        slave_we_o;
    logic [2:0]  slave_ready_i = '0;
    logic [7:0]  slave_rdata_i [3];
    logic [2:0]  slave_err_i = '0;
    logic [7:0]  err_count_o;

    addr_decoder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .we_i(we_i), .ready_o(ready_o), .rdata_o(rdata_o),
        .err_o(err_o), .slave_sel_o(slave_sel_o), .slave_valid_o(slave_valid_o),
        .slave_addr_o(slave_addr_o), .slave_wdata_o(slave_wdata_o), .slave_we_o(slave_we_o),
        .slave_ready_i(slave_ready_i), .slave_rdata_i(slave_rdata_i),
        .slave_err_i(slave_err_i), .err_count_o(err_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic [2:0]  svalid;
        logic [13:0] saddr;
        logic [7:0]  swdata;
        logic        swe;
        logic        ready;
        logic        err;
        logic [7:0]  rdata;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            check({e.name, "/sel"},    32'(slave_sel_o),   32'(e.sel));
            check({e.name, "/svalid"}, 32'(slave_valid_o), 32'(e.svalid));
            check({e.name, "/saddr"},  32'(slave_addr_o),  32'(e.saddr));
            check({e.name, "/swdata"}, 32'(slave_wdata_o), 32'(e.swdata));
            check({e.name, "/swe"},    32'(slave_we_o),    32'(e.swe));
            check({e.name, "/ready"},  32'(ready_o),       32'(e.ready));
            check({e.name, "/err"},    32'(err_o),         32'(e.err));
            check({e.name, "/rdata"},  32'(rdata_o),       32'(e.rdata));
            check({e.name, "/cnt"},    32'(err_count_o),   32'(e.cnt));
        end
    end

    // Drive one cycle of stimulus and queue the hand-computed response.
    task automatic vec(input string name, input logic rst, input logic v, input logic [13:0] a,
                       input logic w, input logic [7:0] wd, input logic [2:0] sr, input logic [2:0] se,
                       input logic [2:0] e_sel, input logic [13:0] e_saddr,
                       input logic e_ready, input logic e_err, input logic [7:0] e_rdata);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_ni = rst; valid_i = v; addr_i = a; we_i = w; wdata_i = wd;
        slave_ready_i = sr; slave_err_i = se;
        if (!rst) exp_cnt = 8'd0;
        e.name = name; e.sel = e_sel; e.svalid = v ? e_sel : 3'b000; e.saddr = e_saddr;
        e.swdata = wd; e.swe = w; e.ready = e_ready; e.err = e_err; e.rdata = e_rdata;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        if (rst && e_ready && e_err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    endtask

    initial begin
        slave_rdata_i[0] = 8'hAB;
        slave_rdata_i[1] = 8'hCD;
        slave_rdata_i[2] = 8'hEF;

        vec("reset_idle", 1'b0, 1'b0, 14'h0000, 1'b0, 8'h00, 3'b000, 3'b000, 3'b001, 14'h0000, 1'b0, 1'b0, 8'hAB);
        vec("idle",       1'b1, 1'b0, 14'h0000, 1'b0, 8'h00, 3'b000, 3'b000, 3'b001, 14'h0000, 1'b0, 1'b0, 8'hAB);

        vec("dec_0000", 1'b1, 1'b1, 14'h0000, 1'b1, 8'h42, 3'b111, 3'b000, 3'b001, 14'h0000, 1'b1, 1'b0, 8'hAB);
        vec("dec_0FFF", 1'b1, 1'b1, 14'h0FFF, 1'b1, 8'h42, 3'b111, 3'b000, 3'b001, 14'h0FFF, 1'b1, 1'b0, 8'hAB);
        vec("dec_1000", 1'b1, 1'b1, 14'h1000, 1'b1, 8'h42, 3'b111, 3'b000, 3'b010, 14'h0000, 1'b1, 1'b0, 8'hCD);
        vec("dec_1FFF", 1'b1, 1'b1, 14'h1FFF, 1'b1, 8'h42, 3'b111, 3'b000, 3'b010, 14'h0FFF, 1'b1, 1'b0, 8'hCD);
        vec("dec_2000", 1'b1, 1'b1, 14'h2000, 1'b1, 8'h42, 3'b111, 3'b000, 3'b100, 14'h0000, 1'b1, 1'b0, 8'hEF);
        vec("dec_27FF", 1'b1, 1'b1, 14'h27FF, 1'b1, 8'h42, 3'b111, 3'b000, 3'b100, 14'h07FF, 1'b1, 1'b0, 8'hEF);

        for (int i = 0; i < 3; i++)
            vec("unmap_2800", 1'b1, 1'b1, 14'h2800, 1'b1, 8'h42, 3'b111, 3'b000, 3'b000, 14'h2800, 1'b1, 1'b1, 8'h00);
        vec("unmap_3FFF", 1'b1, 1'b1, 14'h3FFF, 1'b0, 8'h17, 3'b000, 3'b000, 3'b000, 14'h3FFF, 1'b1, 1'b1, 8'h00);
        vec("unmap_idle", 1'b1, 1'b0, 14'h3FFF, 1'b0, 8'h17, 3'b000, 3'b000, 3'b000, 14'h3FFF, 1'b0, 1'b0, 8'h00);

        vec("rd_0500", 1'b1, 1'b1, 14'h0500, 1'b0, 8'h00, 3'b001, 3'b000, 3'b001, 14'h0500, 1'b1, 1'b0, 8'hAB);
        vec("rd_1800", 1'b1, 1'b1, 14'h1800, 1'b0, 8'h00, 3'b010, 3'b000, 3'b010, 14'h0800, 1'b1, 1'b0, 8'hCD);
        vec("rd_2100", 1'b1, 1'b1, 14'h2100, 1'b0, 8'h00, 3'b100, 3'b000, 3'b100, 14'h0100, 1'b1, 1'b0, 8'hEF);

        vec("tr_0100", 1'b1, 1'b1, 14'h0100, 1'b0, 8'h00, 3'b111, 3'b000, 3'b001, 14'h0100, 1'b1, 1'b0, 8'hAB);
        vec("tr_1100", 1'b1, 1'b1, 14'h1100, 1'b0, 8'h00, 3'b111, 3'b000, 3'b010, 14'h0100, 1'b1, 1'b0, 8'hCD);
        vec("tr_2100", 1'b1, 1'b1, 14'h2100, 1'b0, 8'h00, 3'b111, 3'b000, 3'b100, 14'h0100, 1'b1, 1'b0, 8'hEF);

        vec("serr_0", 1'b1, 1'b1, 14'h0100, 1'b0, 8'h00, 3'b001, 3'b001, 3'b001, 14'h0100, 1'b1, 1'b1, 8'hAB);
        vec("serr_1", 1'b1, 1'b1, 14'h1100, 1'b0, 8'h00, 3'b010, 3'b010, 3'b010, 14'h0100, 1'b1, 1'b1, 8'hCD);
        vec("serr_2", 1'b1, 1'b1, 14'h2100, 1'b0, 8'h00, 3'b100, 3'b100, 3'b100, 14'h0100, 1'b1, 1'b1, 8'hEF);
        vec("serr_other", 1'b1, 1'b1, 14'h2100, 1'b0, 8'h00, 3'b100, 3'b011, 3'b100, 14'h0100, 1'b1, 1'b0, 8'hEF);

        for (int i = 0; i < 16; i++)
            vec("wd_stall", 1'b1, 1'b1, 14'h1000, 1'b0, 8'h00, 3'b000, 3'b000, 3'b010, 14'h0000, 1'b0, 1'b0, 8'hCD);
        vec("wd_timeout", 1'b1, 1'b1, 14'h1000, 1'b0, 8'h00, 3'b000, 3'b000, 3'b010, 14'h0000, 1'b1, 1'b1, 8'hCD);
        for (int i = 0; i < 5; i++)
            vec("wd_restart", 1'b1, 1'b1, 14'h1000, 1'b0, 8'h00, 3'b000, 3'b000, 3'b010, 14'h0000, 1'b0, 1'b0, 8'hCD);
        for (int i = 0; i < 2; i++)
            vec("wd_reset", 1'b0, 1'b1, 14'h1000, 1'b0, 8'h00, 3'b000, 3'b000, 3'b010, 14'h0000, 1'b0, 1'b0, 8'hCD);
        for (int i = 0; i < 16; i++)
            vec("wd_stall2", 1'b1, 1'b1, 14'h1000, 1'b0, 8'h00, 3'b000, 3'b000, 3'b010, 14'h0000, 1'b0, 1'b0, 8'hCD);
        vec("wd_timeout2", 1'b1, 1'b1, 14'h1000, 1'b0, 8'h00, 3'b000, 3'b000, 3'b010, 14'h0000, 1'b1, 1'b1, 8'hCD);

        for (int i = 0; i < 262; i++)
            vec("sat", 1'b1, 1'b1, 14'h3FFF, 1'b0, 8'h00, 3'b000, 3'b000, 3'b000, 14'h3FFF, 1'b1, 1'b1, 8'h00);
        vec("sat_idle", 1'b1, 1'b0, 14'h3FFF, 1'b0, 8'h00, 3'b000, 3'b000, 3'b000, 14'h3FFF, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk_i);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never checked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
